// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI4-Lite responder backed by a word-addressed SRAM.
// Independent read and write FSMs, one outstanding transaction each.
// Byte strobes honoured on writes; addresses outside the window return DECERR.
// Optional macro AXI_LITE_SRAM_READ_WAIT_EN inserts READ_WAIT extra read cycles.
module axi_lite_sram_slave #(
    parameter int                            C_S_AXI_ADDR_WIDTH = 64,
    parameter int                            C_S_AXI_DATA_WIDTH = 64,
    parameter int                            DEPTH              = 4096,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0,
    parameter int                            READ_WAIT          = 2
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [AW-1:0] SPAN = AW'(DEPTH) << 3;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
`ifdef AXI_LITE_SRAM_READ_WAIT_EN
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    logic [31:0] wait_cnt;
`else
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
`endif

    w_state_t w_state;
    r_state_t r_state;

    logic [DW-1:0] mem [DEPTH];

    logic          aw_have, w_have;
    logic [AW-1:0] awaddr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;

    logic          aw_hs, w_hs, aw_done, w_done, wr_commit, wr_in_range;
    logic [AW-1:0] wr_addr, wr_off;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic [IDX_W-1:0] wr_idx;

    logic          ar_in_range;
    logic [AW-1:0] ar_off;
    logic [IDX_W-1:0] ar_idx;

    // PROT is deliberately ignored; READ_WAIT only matters in the wait build
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, (READ_WAIT != 0)};

    // Write commit decode: the second of AW/W may arrive on this edge, so bypass the capture regs
    always_comb begin
        aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
        w_hs        = S_AXI_WVALID & S_AXI_WREADY;
        aw_done     = aw_have | aw_hs;
        w_done      = w_have | w_hs;
        wr_commit   = (w_state == W_IDLE) & aw_done & w_done;
        wr_addr     = aw_hs ? S_AXI_AWADDR : awaddr_q;
        wr_data     = w_hs ? S_AXI_WDATA : wdata_q;
        wr_strb     = w_hs ? S_AXI_WSTRB : wstrb_q;
        wr_off      = wr_addr - BASE_ADDR;
        wr_in_range = (wr_addr >= BASE_ADDR) && (wr_off < SPAN);
        wr_idx      = wr_off[3 +: IDX_W];
    end

    // Read address decode
    always_comb begin
        ar_off      = S_AXI_ARADDR - BASE_ADDR;
        ar_in_range = (S_AXI_ARADDR >= BASE_ADDR) && (ar_off < SPAN);
        ar_idx      = ar_off[3 +: IDX_W];
    end

    // SRAM byte-lane write; contents are intentionally not reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_commit && wr_in_range) begin
            for (int unsigned i = 0; i < SW; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Write FSM: collect AW and W in any order, commit, then hold B until accepted
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state       <= W_IDLE;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= '0;
            aw_have       <= 1'b0;
            w_have        <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (wr_commit) begin
                        S_AXI_AWREADY <= 1'b0;
                        S_AXI_WREADY  <= 1'b0;
                        aw_have       <= 1'b0;
                        w_have        <= 1'b0;
                        S_AXI_BVALID  <= 1'b1;
                        S_AXI_BRESP   <= wr_in_range ? RESP_OKAY : RESP_DECERR;
                        w_state       <= W_RESP;
                    end else begin
                        if (aw_hs) begin
                            aw_have  <= 1'b1;
                            awaddr_q <= S_AXI_AWADDR;
                        end
                        if (w_hs) begin
                            w_have  <= 1'b1;
                            wdata_q <= S_AXI_WDATA;
                            wstrb_q <= S_AXI_WSTRB;
                        end
                        S_AXI_AWREADY <= !aw_done;
                        S_AXI_WREADY  <= !w_done;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        S_AXI_BVALID  <= 1'b0;
                        S_AXI_AWREADY <= 1'b1;
                        S_AXI_WREADY  <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM: capture RAM word (read-before-write) at AR, optionally wait, then hold R until accepted
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state       <= R_IDLE;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RRESP   <= '0;
            S_AXI_RDATA   <= '0;
`ifdef AXI_LITE_SRAM_READ_WAIT_EN
            wait_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
                        S_AXI_ARREADY <= 1'b0;
                        S_AXI_RDATA   <= ar_in_range ? mem[ar_idx] : '0;
                        S_AXI_RRESP   <= ar_in_range ? RESP_OKAY : RESP_DECERR;
`ifdef AXI_LITE_SRAM_READ_WAIT_EN
                        if (READ_WAIT == 0) begin
                            S_AXI_RVALID <= 1'b1;
                            r_state      <= R_DATA;
                        end else begin
                            wait_cnt <= 32'(READ_WAIT - 1);
                            r_state  <= R_WAIT;
                        end
`else
                        S_AXI_RVALID  <= 1'b1;
                        r_state       <= R_DATA;
`endif
                    end else begin
                        S_AXI_ARREADY <= 1'b1;
                    end
                end
`ifdef AXI_LITE_SRAM_READ_WAIT_EN
                R_WAIT: begin
                    if (wait_cnt == '0) begin
                        S_AXI_RVALID <= 1'b1;
                        r_state      <= R_DATA;
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end
`endif
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        S_AXI_RVALID  <= 1'b0;
                        S_AXI_ARREADY <= 1'b1;
                        r_state       <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Testbench for axi_lite_sram_slave: directed cases plus randomized traffic
// checked against a byte-level memory model.
module tb_axi_lite_sram_slave;

    localparam int          DEPTH = 4096;
    localparam logic [63:0] BASE  = 64'h0;
    localparam int          RW    = 2;
`ifdef AXI_LITE_SRAM_READ_WAIT_EN
    localparam int RD_LAT = RW;
`else
    localparam int RD_LAT = 0;
`endif
    localparam logic [63:0] TOP = 64'(DEPTH) * 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic [2:0]  awprot = '0, arprot = '0;
    logic [7:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] mem_m [DEPTH];
    logic [7:0]  known [DEPTH];

    axi_lite_sram_slave #(
        .C_S_AXI_ADDR_WIDTH(64),
        .C_S_AXI_DATA_WIDTH(64),
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE),
        .READ_WAIT(RW)
    ) dut (
        .S_AXI_ACLK(clk),       .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr),  .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata),    .S_AXI_WSTRB(wstrb),   .S_AXI_WVALID(wvalid),   .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp),    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr),  .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata),    .S_AXI_RRESP(rresp),   .S_AXI_RVALID(rvalid),   .S_AXI_RREADY(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < TOP);
    endfunction

    function automatic int unsigned widx(input logic [63:0] a);
        logic [63:0] w;
        w = (a - BASE) / 8;
        return int'(w[31:0]);
    endfunction

    function automatic logic [63:0] lanes(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [63:0] a);
        int n = 0;
        awaddr  = a;
        awprot  = 3'($urandom_range(0, 7));
        awvalid = 1'b1;
        while (!awready && n < 50) begin tick(); n++; end
        if (!awready) check("aw_timeout", 64'(awready), 64'd1);
        else tick();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        int n = 0;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        while (!wready && n < 50) begin tick(); n++; end
        if (!wready) check("w_timeout", 64'(wready), 64'd1);
        else tick();
        wvalid = 1'b0;
    endtask

    task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int aw_lead, input int w_lead, input int b_delay);
        bit ok;
        int unsigned idx;
        ok = addr_ok(a);
        fork
            begin
                for (int i = 0; i < aw_lead; i++) begin tick(); check("b_early", 64'(bvalid), 64'd0); end
                send_aw(a);
            end
            begin
                for (int j = 0; j < w_lead; j++) tick();
                send_w(d, s);
            end
        join
        check("b_lat", 64'(bvalid), 64'd1);
        check("bresp", 64'(bresp), ok ? 64'd0 : 64'd3);
        if (ok) begin
            idx = widx(a);
            for (int k = 0; k < 8; k++) begin
                if (s[k]) begin
                    mem_m[idx][8*k +: 8] = d[8*k +: 8];
                    known[idx][k] = 1'b1;
                end
            end
        end
        for (int i = 0; i < b_delay; i++) begin
            tick();
            check("b_hold", 64'(bvalid), 64'd1);
            check("bresp_hold", 64'(bresp), ok ? 64'd0 : 64'd3);
            check("aw_blocked", 64'(awready), 64'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done", 64'(bvalid), 64'd0);
    endtask

    task automatic axi_read(input logic [63:0] a, input int r_delay);
        logic [63:0] exp, msk, first;
        logic [1:0]  er;
        int n = 0;
        if (addr_ok(a)) begin
            exp = mem_m[widx(a)];
            msk = lanes(known[widx(a)]);
            er  = 2'b00;
        end else begin
            exp = '0;
            msk = '1;
            er  = 2'b11;
        end
        araddr  = a;
        arprot  = 3'($urandom_range(0, 7));
        arvalid = 1'b1;
        while (!arready && n < 50) begin tick(); n++; end
        if (!arready) check("ar_timeout", 64'(arready), 64'd1);
        else tick();
        arvalid = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            check("r_wait", 64'(rvalid), 64'd0);
            check("ar_wait", 64'(arready), 64'd0);
            tick();
        end
        check("r_lat", 64'(rvalid), 64'd1);
        check("rresp", 64'(rresp), 64'(er));
        if (msk != '0) check("rdata", rdata & msk, exp & msk);
        first = rdata;
        for (int i = 0; i < r_delay; i++) begin
            tick();
            check("r_hold", 64'(rvalid), 64'd1);
            check("rdata_hold", rdata, first);
            check("ar_blocked", 64'(arready), 64'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("r_done", 64'(rvalid), 64'd0);
    endtask

    initial begin
        logic [63:0] a;
        for (int i = 0; i < DEPTH; i++) begin mem_m[i] = '0; known[i] = '0; end

        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready",  64'(wready),  64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid",  64'(bvalid),  64'd0);
        check("rst_rvalid",  64'(rvalid),  64'd0);
        check("rst_bresp",   64'(bresp),   64'd0);
        check("rst_rresp",   64'(rresp),   64'd0);
        check("rst_rdata",   rdata,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rel_awready", 64'(awready), 64'd1);
        check("rel_wready",  64'(wready),  64'd1);
        check("rel_arready", 64'(arready), 64'd1);

        // basic write/readback
        axi_write(64'h10, 64'h1122334455667788, 8'hFF, 0, 0, 0);
        axi_read(64'h10, 0);
        // W three cycles ahead of AW, partial strobe
        axi_write(64'h10, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 3, 0, 0);
        axi_read(64'h10, 0);
        check("strb_merge", rdata, 64'h11223344AAAAAAAA);
        // AW ahead of W, held B
        axi_write(64'h18, 64'h0123456789ABCDEF, 8'hF0, 0, 2, 3);
        axi_read(64'h18, 0);

        // window boundaries; out-of-range write must not alias onto word 0
        axi_write(64'h0, 64'hDEADBEEFCAFEF00D, 8'hFF, 0, 0, 0);
        axi_write(TOP - 8, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 0, 0, 0);
        axi_read(TOP - 8, 0);
        axi_read(TOP, 0);
        axi_write(TOP, 64'h5555555555555555, 8'hFF, 0, 0, 1);
        axi_read(64'h0, 0);
        axi_read(64'hFFFFFFFFFFFFFFF8, 2);

        // R backpressure
        axi_read(64'h10, 5);

        // same-edge AR and write commit: read sees the old word
        axi_write(64'h20, 64'h5, 8'hFF, 0, 0, 0);
        fork
            axi_write(64'h20, 64'h9, 8'hFF, 0, 0, 0);
            axi_read(64'h20, 0);
        join
        axi_read(64'h20, 0);

        // reset while BVALID is pending
        awaddr = 64'h30; wdata = 64'h3030303030303030; wstrb = 8'hFF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("pre_rst_bvalid", 64'(bvalid), 64'd1);
        mem_m[6] = 64'h3030303030303030;
        known[6] = 8'hFF;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid",  64'(bvalid),  64'd0);
        check("mid_rst_awready", 64'(awready), 64'd0);
        check("mid_rst_arready", 64'(arready), 64'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_awready", 64'(awready), 64'd1);
        check("post_rst_wready",  64'(wready),  64'd1);
        check("post_rst_arready", 64'(arready), 64'd1);
        axi_read(64'h30, 0);

        // randomized traffic over a small word set plus occasional out-of-range hits
        for (int w = 0; w < 16; w++) axi_write(64'(w) * 8, {$urandom, $urandom}, 8'hFF, 0, 0, 0);
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 5) == 0)
                a = ($urandom_range(0, 1) == 0) ? TOP + 64'($urandom_range(0, 255)) : 64'hFFFFFFFFFFFFFFF0;
            else
                a = 64'($urandom_range(0, 15)) * 8 + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
                          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            else
                axi_read(a, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
